// File: rtl/afifo_rd_burst_engine.sv
// Burst read engine for the read side of an async FIFO: runs N-beat read commands into a valid/ready consumer.
// Latency: first beat reaches dout RD_LATENCY+1 edges after accept; 1 beat/cycle sustained afterwards.
// Backpressure: rinc is issued only while buffered + in-flight beats leave room in the OUT_DEPTH output buffer.
//
// Ports:
//   rclk, rrst            read clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_len (beats-1), cmd_mode (0 wait, 1 abort on empty),
//                         cmd_timeout (consecutive-stall limit, 0 disables)
//   rempty/rinc/rdata     FIFO read port
//   dout_valid/ready/data/last   output stream; last only on the final beat of a fully completed burst
//   done/done_status      completion pulse and status (00 ok, 01 aborted-empty, 10 timeout)
//   beats_done/stall_cnt  beats issued and empty-stall cycles of the last/current burst
module afifo_rd_burst_engine #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned LEN_WIDTH   = 8,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned OUT_DEPTH   = 4,
    parameter int unsigned TO_WIDTH    = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_mode,
    input  logic [TO_WIDTH-1:0]   cmd_timeout,
    input  logic                  rempty,
    output logic                  rinc,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_last,
    output logic                  done,
    output logic [1:0]            done_status,
    output logic [LEN_WIDTH:0]    beats_done,
    output logic [15:0]           stall_cnt
);

    // ADDR_WIDTH is informational only; it does not change the beat counter width.
    localparam int unsigned BEAT_W = LEN_WIDTH + 1 + 0 * ADDR_WIDTH;
    localparam int unsigned PL     = (RD_LATENCY == 0) ? 1 : RD_LATENCY;
    localparam int unsigned AW     = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CW     = $clog2(OUT_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LEN_WIDTH-1:0]  r_len;
    logic                  r_mode;
    logic [TO_WIDTH-1:0]   r_timeout;
    logic [BEAT_W-1:0]     r_issued;
    logic [TO_WIDTH-1:0]   r_to_cnt;
    logic [15:0]           r_stall_cnt;
    logic [1:0]            r_status;

    logic [PL-1:0]         r_pipe_vld;
    logic [PL-1:0]         r_pipe_last;
    logic [DATA_WIDTH-1:0] r_mem      [0:(1<<AW)-1];
    logic                  r_mem_last [0:(1<<AW)-1];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;

    logic [BEAT_W-1:0]     w_total;
    logic                  w_more;
    logic [CW-1:0]         w_in_flight;
    logic                  w_credit_ok;
    logic                  w_rinc;
    logic                  w_issue_last;
    logic                  w_stall;
    logic                  w_abort;
    logic                  w_timeout;
    logic                  w_accept;
    logic                  w_cap_vld;
    logic                  w_cap_last;
    logic                  w_pop;
    logic                  w_drained;
    logic                  w_fin;
    logic [1:0]            w_fin_status;

    assign w_total  = {1'b0, r_len} + BEAT_W'(1);
    assign w_more   = (r_issued < w_total);
    assign w_accept = (r_state == S_IDLE) && cmd_valid;

    always_comb begin
        w_in_flight = '0;
        for (int i = 0; i < PL; i++) begin
            w_in_flight = w_in_flight + CW'(r_pipe_vld[i]);
        end
    end

    // Reserve a buffer slot for every beat already requested but not yet captured.
    assign w_credit_ok  = ({1'b0, w_in_flight} + {1'b0, r_count}) < (CW+1)'(OUT_DEPTH);
    assign w_rinc       = (r_state == S_RUN) && !rempty && w_more && w_credit_ok && !rrst;
    assign w_issue_last = w_rinc && ((r_issued + BEAT_W'(1)) == w_total);
    assign rinc         = w_rinc;

    // Credit-blocked cycles are not stalls: only an empty FIFO with beats outstanding counts.
    assign w_stall   = (r_state == S_RUN) && rempty && w_more;
    assign w_abort   = w_stall && r_mode;
    assign w_timeout = w_stall && (r_timeout != '0) &&
                       (({1'b0, r_to_cnt} + (TO_WIDTH+1)'(1)) >= {1'b0, r_timeout});

    assign w_cap_vld  = (RD_LATENCY == 0) ? w_rinc       : r_pipe_vld[PL-1];
    assign w_cap_last = (RD_LATENCY == 0) ? w_issue_last : r_pipe_last[PL-1];
    assign w_pop      = dout_valid && dout_ready;
    assign w_drained  = (w_in_flight == '0) && (r_count == '0);

    always_comb begin
        w_state_nxt  = r_state;
        w_fin        = 1'b0;
        w_fin_status = 2'b00;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_state_nxt = S_RUN;
            S_RUN: begin
                if (!w_more) begin
                    w_state_nxt  = S_DRAIN;
                    w_fin        = 1'b1;
                    w_fin_status = 2'b00;
                end else if (w_abort) begin
                    w_state_nxt  = S_DRAIN;
                    w_fin        = 1'b1;
                    w_fin_status = 2'b01;
                end else if (w_timeout) begin
                    w_state_nxt  = S_DRAIN;
                    w_fin        = 1'b1;
                    w_fin_status = 2'b10;
                end
            end
            S_DRAIN: if (w_drained) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_mode      <= 1'b0;
            r_timeout   <= '0;
            r_issued    <= '0;
            r_to_cnt    <= '0;
            r_stall_cnt <= '0;
            r_status    <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_len       <= cmd_len;
                r_mode      <= cmd_mode;
                r_timeout   <= cmd_timeout;
                r_issued    <= '0;
                r_to_cnt    <= '0;
                r_stall_cnt <= '0;
                r_status    <= 2'b00;
            end else begin
                if (w_rinc) begin
                    r_issued <= r_issued + BEAT_W'(1);
                    r_to_cnt <= '0;
                end else if (w_stall) begin
                    if (r_to_cnt != '1)
                        r_to_cnt <= r_to_cnt + TO_WIDTH'(1);
                    if (r_stall_cnt != 16'hFFFF)
                        r_stall_cnt <= r_stall_cnt + 16'd1;
                end
                if (w_fin)
                    r_status <= w_fin_status;
            end
        end
    end

    // In-flight tracker and output buffer pointers; a reset drops everything in transit.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_pipe_vld  <= '0;
            r_pipe_last <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
        end else begin
            if (RD_LATENCY > 0) begin
                r_pipe_vld[0]  <= w_rinc;
                r_pipe_last[0] <= w_issue_last;
                for (int i = 1; i < PL; i++) begin
                    r_pipe_vld[i]  <= r_pipe_vld[i-1];
                    r_pipe_last[i] <= r_pipe_last[i-1];
                end
            end
            if (w_cap_vld)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            if (w_cap_vld && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_cap_vld && w_pop)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge rclk) begin
        if (w_cap_vld) begin
            r_mem[r_wptr]      <= rdata;
            r_mem_last[r_wptr] <= w_cap_last;
        end
    end

    assign dout_valid  = (r_count != '0);
    assign dout_data   = r_mem[r_rptr];
    assign dout_last   = dout_valid && r_mem_last[r_rptr];
    assign cmd_ready   = (r_state == S_IDLE);
    assign done        = (r_state == S_DONE);
    assign done_status = r_status;
    assign beats_done  = r_issued;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_afifo_rd_burst_engine.sv
module tb_afifo_rd_burst_engine;
    localparam int LW  = 8;
    localparam int TW  = 16;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_mode = 1'b0;
    logic [TW-1:0] cmd_timeout = '0;
    logic          rempty;
    logic          rinc;
    logic [DW-1:0] rdata;
    logic          dout_valid;
    logic          dout_ready = 1'b1;
    logic [DW-1:0] dout_data;
    logic          dout_last;
    logic          done;
    logic [1:0]    done_status;
    logic [LW:0]   beats_done;
    logic [15:0]   stall_cnt;

    afifo_rd_burst_engine #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(8), .LEN_WIDTH(LW),
        .RD_LATENCY(LAT), .OUT_DEPTH(4), .TO_WIDTH(TW)
    ) dut (
        .rclk(rclk), .rrst(rrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_mode(cmd_mode), .cmd_timeout(cmd_timeout),
        .rempty(rempty), .rinc(rinc), .rdata(rdata),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .dout_last(dout_last), .done(done), .done_status(done_status),
        .beats_done(beats_done), .stall_cnt(stall_cnt)
    );

    always #5 rclk = ~rclk;

    // FIFO model with a two-cycle read latency; write side is driven from the test at negedges.
    logic [DW-1:0] fmem [0:1023];
    int            f_wr = 0;
    int            f_rd = 0;
    bit            flush_req = 1'b0;
    logic [DW-1:0] d1, d2;
    assign rempty = (f_rd == f_wr);
    assign rdata  = d2;
    always @(posedge rclk) begin
        if (flush_req) f_rd <= f_wr;
        else if (rinc) begin
            d1   <= fmem[f_rd % 1024];
            f_rd <= f_rd + 1;
        end
        d2 <= d1;
    end

    // Monitor: rinc edges, done pulses, accepted output beats.
    int            cyc = 0, rinc_n = 0, done_n = 0, out_n = 0;
    int            rinc_cyc [0:1023];
    logic [DW-1:0] out_dat  [0:1023];
    logic          out_last [0:1023];
    always @(posedge rclk) begin
        cyc <= cyc + 1;
        if (rinc) begin
            rinc_cyc[rinc_n % 1024] <= cyc;
            rinc_n <= rinc_n + 1;
        end
        if (done) done_n <= done_n + 1;
        if (dout_valid && dout_ready && !rrst) begin
            out_dat[out_n % 1024]  <= dout_data;
            out_last[out_n % 1024] <= dout_last;
            out_n <= out_n + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        int       len;
        bit       mode;
        int       tmo;
        int       pre;
        int       late_at;
        int       late_n;
        int       hold;
        int       hold_rinc;
        int       beats;
        logic [1:0] status;
        int       stall;      // -1: not checked
        bit       last;
        int       span;       // -1: not checked
    } vec_t;

    function automatic vec_t mk(int len, bit mode, int tmo, int pre, int late_at, int late_n,
                                int hold, int hold_rinc, int beats, logic [1:0] status,
                                int stall, bit last, int span);
        vec_t t;
        t.len = len; t.mode = mode; t.tmo = tmo; t.pre = pre; t.late_at = late_at;
        t.late_n = late_n; t.hold = hold; t.hold_rinc = hold_rinc; t.beats = beats;
        t.status = status; t.stall = stall; t.last = last; t.span = span;
        return t;
    endfunction

    task automatic push_word(input logic [DW-1:0] w);
        fmem[f_wr % 1024] = w;
        f_wr++;
    endtask

    task automatic flush_fifo();
        @(negedge rclk) flush_req = 1'b1;
        @(negedge rclk) flush_req = 1'b0;
    endtask

    task automatic run_vec(input int v, input vec_t t);
        int  base, ob, rb;
        bit  seen;
        base = (v + 1) << 12;
        flush_fifo();
        for (int i = 0; i < t.pre; i++) push_word(DW'(base + i));
        dout_ready  = (t.hold == 0);
        cmd_len     = LW'(t.len);
        cmd_mode    = t.mode;
        cmd_timeout = TW'(t.tmo);
        cmd_valid   = 1'b1;
        chk($sformatf("v%0d cmd_ready idle", v), cmd_ready, 1);
        ob = out_n;
        rb = rinc_n;
        @(posedge rclk);
        @(negedge rclk);
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            if (c == t.late_at)
                for (int k = 0; k < t.late_n; k++) push_word(DW'(base + t.pre + k));
            if (t.hold > 0 && c == t.hold) begin
                chk($sformatf("v%0d rinc under backpressure", v), rinc_n - rb, t.hold_rinc);
                chk($sformatf("v%0d dout_valid held", v), dout_valid, 1);
                dout_ready = 1'b1;
            end
            if (done) begin
                seen = 1'b1;
                chk($sformatf("v%0d done_status", v), done_status, t.status);
                chk($sformatf("v%0d beats_done", v), beats_done, t.beats);
                if (t.stall >= 0)
                    chk($sformatf("v%0d stall_cnt", v), stall_cnt, t.stall);
            end else begin
                @(posedge rclk);
                @(negedge rclk);
            end
        end
        chk($sformatf("v%0d done seen within budget", v), seen, 1);
        @(posedge rclk);
        @(negedge rclk);
        chk($sformatf("v%0d done one cycle", v), done, 0);
        chk($sformatf("v%0d status held", v), done_status, t.status);
        chk($sformatf("v%0d rinc count", v), rinc_n - rb, t.beats);
        chk($sformatf("v%0d output beats", v), out_n - ob, t.beats);
        for (int i = 0; i < t.beats && i < out_n - ob; i++) begin
            chk($sformatf("v%0d beat %0d data", v, i), out_dat[(ob + i) % 1024], base + i);
            chk($sformatf("v%0d beat %0d last", v, i), out_last[(ob + i) % 1024],
                (t.last && i == t.beats - 1) ? 1 : 0);
        end
        if (t.span > 0 && rinc_n - rb == t.beats)
            chk($sformatf("v%0d rinc span", v),
                rinc_cyc[(rb + t.beats - 1) % 1024] - rinc_cyc[rb % 1024] + 1, t.span);
    endtask

    vec_t vt [0:7];

    initial begin
        int rb, db, base;
        vt[0] = mk(7,  0, 0, 8,  -1, 0, 0,  0, 8,  2'b00, 0,  1, 8);   // back-to-back burst
        vt[1] = mk(3,  0, 0, 2,  12, 2, 0,  0, 4,  2'b00, 10, 1, -1);  // wait through 10 empty cycles
        vt[2] = mk(5,  1, 0, 3,  -1, 0, 0,  0, 3,  2'b01, -1, 0, -1);  // abort on empty
        vt[3] = mk(3,  0, 5, 0,  -1, 0, 0,  0, 0,  2'b10, 5,  0, -1);  // timeout, nothing issued
        vt[4] = mk(15, 0, 0, 16, -1, 0, 20, 4, 16, 2'b00, 0,  1, -1);  // consumer stalled 20 cycles
        vt[5] = mk(3,  0, 5, 2,  6,  2, 0,  0, 4,  2'b00, 4,  1, -1);  // stalls one short of timeout
        vt[6] = mk(3,  0, 4, 2,  6,  2, 0,  0, 2,  2'b10, 4,  0, -1);  // stalls exactly at timeout
        vt[7] = mk(0,  0, 0, 1,  -1, 0, 0,  0, 1,  2'b00, 0,  1, -1);  // single-beat burst

        repeat (3) @(posedge rclk);
        @(negedge rclk);
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset rinc", rinc, 0);
        chk("reset dout_valid", dout_valid, 0);
        chk("reset dout_last", dout_last, 0);
        chk("reset done", done, 0);
        chk("reset done_status", done_status, 0);
        chk("reset beats_done", beats_done, 0);
        chk("reset stall_cnt", stall_cnt, 0);
        rrst = 1'b0;

        for (int v = 0; v < 8; v++) run_vec(v, vt[v]);

        // Reset in the middle of a burst after three beats have been issued.
        base = 32'hA000;
        flush_fifo();
        for (int i = 0; i < 8; i++) push_word(DW'(base + i));
        dout_ready = 1'b1;
        cmd_len = LW'(7); cmd_mode = 1'b0; cmd_timeout = '0; cmd_valid = 1'b1;
        rb = rinc_n;
        @(posedge rclk);
        @(negedge rclk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 50 && (rinc_n - rb) < 3; c++) begin
            @(posedge rclk);
            @(negedge rclk);
        end
        chk("midreset three beats issued", rinc_n - rb, 3);
        rrst = 1'b1;
        db = done_n;
        #1;
        chk("midreset rinc forced low", rinc, 0);
        @(posedge rclk);
        @(negedge rclk);
        chk("midreset dout_valid", dout_valid, 0);
        chk("midreset cmd_ready", cmd_ready, 1);
        chk("midreset done", done, 0);
        chk("midreset beats_done", beats_done, 0);
        rrst = 1'b0;
        repeat (4) @(posedge rclk);
        @(negedge rclk);
        chk("midreset no done pulse", done_n - db, 0);
        run_vec(8, vt[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
